// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared register offsets, CTRL bit indices, FSM states and timing defaults
package ir_pkg;

    localparam int TIMER_W             = 24;
    localparam int DEF_PKT_PERIOD      = 10_000_000;
    localparam int DEF_PKT_BUSY_CYCLES = 4_000_000;

    localparam logic [1:0] REG_CMD  = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_GO_BIT   = 1;
    localparam int CTRL_IE_BIT   = 2;
    localparam int CTRL_BUSY_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_BUSY = 2'd2,
        ST_WAIT = 2'd3
    } ir_state_e;

endpackage

// File: rtl/ir_period_timer.sv
// rtl/ir_period_timer.sv - 24-bit packet period counter with synchronous clear and count enable
module ir_period_timer
    import ir_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // clear wins over enable so the count reads 0 in the cycle after a clear
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ir_bus_interface.sv
// rtl/ir_bus_interface.sv - bus-mapped IR packet scheduler; IR_BUS_IRQ_EN enables the busy-done interrupt
module ir_bus_interface
    import ir_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR       = 8'h90,
    parameter int         PKT_PERIOD      = DEF_PKT_PERIOD,
    parameter int         PKT_BUSY_CYCLES = DEF_PKT_BUSY_CYCLES
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA_IN,
    input  logic       BUS_WE,
    output logic [7:0] BUS_DATA_OUT,
    output logic       BUS_DATA_OE,
    output logic [3:0] COMMAND,
    output logic       SEND_PACKET,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam logic [TIMER_W-1:0] BUSY_LAST   = TIMER_W'(PKT_BUSY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(PKT_PERIOD - 1);

    // 9-bit difference so addresses below BASE_ADDR never alias into the window
    logic [8:0] addr_diff;
    logic       in_window;
    logic [1:0] reg_off;
    logic       wr_cmd;
    logic       wr_ctrl;
    logic       wr_cnt;
    logic       rd_req;

    assign addr_diff = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
    assign in_window = (addr_diff < 9'd3);
    assign reg_off   = addr_diff[1:0];
    assign wr_cmd    = BUS_WE && in_window && (reg_off == REG_CMD);
    assign wr_ctrl   = BUS_WE && in_window && (reg_off == REG_CTRL);
    assign wr_cnt    = BUS_WE && in_window && (reg_off == REG_CNT);
    assign rd_req    = !BUS_WE && in_window;

    ir_state_e          state_q, state_d;
    logic [3:0]         cmd_q, cmd_d;
    logic               en_q, en_d;
    logic               go_q, go_d;
    logic               ie_q, ie_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         command_q, command_d;
    logic               raise_q, raise_d;
    logic [7:0]         dout_q, dout_d;
    logic               oe_q, oe_d;
    logic [7:0]         rdata;
    logic               busy;
    logic               busy_done;
    logic [TIMER_W-1:0] period_count;

    // bits that the register map does not decode
    logic [4:0] unused_inputs;
`ifdef IR_BUS_IRQ_EN
    assign unused_inputs = {BUS_DATA_IN[7:4], 1'b0};
`else
    assign unused_inputs = {BUS_DATA_IN[7:4], BUS_INTERRUPT_ACK};
`endif

    assign busy = (state_q == ST_SEND) || (state_q == ST_BUSY);

    // counter restarts on every send and runs while the FSM is active
    ir_period_timer #(
        .W(TIMER_W)
    ) u_period_timer (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .clear  (state_d == ST_SEND),
        .enable (state_q != ST_IDLE),
        .count  (period_count)
    );

    // packet scheduler next-state; >= keeps the FSM from stalling at the smallest legal timings
    always_comb begin
        state_d   = state_q;
        busy_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q || go_q) state_d = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (period_count >= BUSY_LAST) begin
                    state_d   = ST_WAIT;
                    busy_done = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (period_count >= PERIOD_LAST) begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // register file, packet counter, latched command and interrupt request
    always_comb begin
        cmd_d     = cmd_q;
        en_d      = en_q;
        ie_d      = ie_q;
        cnt_d     = cnt_q;
        command_d = command_q;
        raise_d   = raise_q;
        // GO only counts when it lands while idle; anything else is dropped, never queued
        go_d      = wr_ctrl && BUS_DATA_IN[CTRL_GO_BIT] && (state_q == ST_IDLE);

        if (wr_cmd)  cmd_d = BUS_DATA_IN[3:0];
        if (wr_ctrl) en_d  = BUS_DATA_IN[CTRL_EN_BIT];

        if (wr_cnt) begin
            cnt_d = '0;
        end else if (state_q == ST_SEND) begin
            cnt_d = cnt_q + 1'b1;
        end

        // COMMAND is latched on entry to SEND so it is valid alongside the pulse
        if (state_d == ST_SEND) command_d = cmd_q;

`ifdef IR_BUS_IRQ_EN
        if (wr_ctrl) ie_d = BUS_DATA_IN[CTRL_IE_BIT];
        if (busy_done && ie_q) begin
            raise_d = 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            raise_d = 1'b0;
        end
`else
        ie_d    = 1'b0;
        raise_d = 1'b0;
`endif
    end

    // read mux and registered read port (data and OE valid the cycle after the request)
    always_comb begin
        rdata = '0;
        case (reg_off)
            REG_CMD:  rdata[3:0] = cmd_q;
            REG_CTRL: begin
                rdata[CTRL_EN_BIT]   = en_q;
                rdata[CTRL_IE_BIT]   = ie_q;
                rdata[CTRL_BUSY_BIT] = busy;
            end
            REG_CNT:  rdata = cnt_q;
            default:  rdata = '0;
        endcase
        dout_d = rd_req ? rdata : 8'h00;
        oe_d   = rd_req;
    end

    // state and register flops
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            en_q      <= 1'b0;
            go_q      <= 1'b0;
            ie_q      <= 1'b0;
            cnt_q     <= '0;
            command_q <= '0;
            raise_q   <= 1'b0;
            dout_q    <= '0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            en_q      <= en_d;
            go_q      <= go_d;
            ie_q      <= ie_d;
            cnt_q     <= cnt_d;
            command_q <= command_d;
            raise_q   <= raise_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
        end
    end

    assign SEND_PACKET         = (state_q == ST_SEND);
    assign COMMAND             = command_q;
    assign BUS_INTERRUPT_RAISE = raise_q;
    assign BUS_DATA_OUT        = dout_q;
    assign BUS_DATA_OE         = oe_q;

endmodule
